// File: rtl/sync_fifo_pkg.sv
// Shared sizing and pointer helpers for the flagged synchronous FIFO.
// Pure functions only; no latency or backpressure of their own.
package sync_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Wraps with an explicit compare so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags; master drives requests, slave is the FIFO.
// Optional SYNC_FIFO_ERR_FLAGS_EN adds err_clr/overflow/underflow.
interface sync_fifo_flags_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = cnt_width(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, data_in, rd_en, err_clr,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_en, data_in, rd_en, err_clr,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
`else
  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, full, empty, almost_full, almost_empty, count
  );
  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, full, empty, almost_full, almost_empty, count
  );
`endif

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read (1 cycle), no flow control.
// Only the read register is reset; the array itself is left uninitialised.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-slot read/write when full returns the old word (NBA ordering).
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count and threshold flags; data_out valid 1 cycle after an accepted read.
// Full drops writes unless a read frees a slot the same edge; SYNC_FIFO_ERR_FLAGS_EN adds sticky error flags.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty;
  logic          wr_acc, rd_acc;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign rd_acc = bus.rd_en && !empty;
  assign wr_acc = bus.wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
    end
    if (rd_acc) begin
      rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.data_out)
  );

  // Flags come straight from the count register, never from the request inputs.
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.count        = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full && !bus.rd_en) begin
        ovf_q <= 1'b1;
      end else if (bus.err_clr) begin
        ovf_q <= 1'b0;
      end
      if (bus.rd_en && empty) begin
        unf_q <= 1'b1;
      end else if (bus.err_clr) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule
